bin2bcd_seq: RTL

BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

---
 rtl/bin2bcd_seq.sv | 136 +++++++++++++
 1 files changed

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary to 4-digit BCD converter for a 7-seg display mux.
// Latency: BIN_W+1 rising edges from start acceptance to the done pulse.
// Backpressure: start is ignored while busy; no queueing. Macro BIN2BCD_SAT_EN saturates >9999 to 9999 with ovf.
module bin2bcd_seq #(
  parameter int BIN_W = 14
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [BIN_W-1:0] bin,
  output logic             busy,
  output logic             done,
  output logic [3:0]       bcd0,
  output logic [3:0]       bcd1,
  output logic [3:0]       bcd2,
  output logic [3:0]       bcd3,
  output logic             ovf
);

  localparam int CNT_W = $clog2(BIN_W + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [BIN_W-1:0] bin_sh;
  logic [BIN_W-1:0] bin_nxt;
  logic [15:0]      scratch;
  logic [15:0]      scratch_add;
  logic [15:0]      scratch_nxt;
  logic [15:0]      result;
  logic             accept;
  logic             last;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state: accept a request in IDLE, leave SHIFT on the final shift
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    last      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt == CNT_W'(1)) begin
          last      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == SHIFT);

  // Dabble step: add 3 to every nibble of 5 or more before the shift
  always_comb begin
    scratch_add = scratch;
    for (int i = 0; i < 4; i++) begin
      if (scratch[4*i +: 4] >= 4'd5)
        scratch_add[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
    end
  end

  // The carry out of the thousands nibble is dropped, giving the value mod 10000
  assign scratch_nxt = 16'({scratch_add, bin_sh[BIN_W-1]});
  assign bin_nxt     = bin_sh << 1;

`ifdef BIN2BCD_SAT_EN
  logic big;
  logic ovf_q;

  // Flag at capture whether the input needs more than four digits; publish it at done
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      big   <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      if (accept) big   <= (14'(bin) > 14'd9999);
      if (last)   ovf_q <= big;
    end
  end

  assign result = big ? 16'h9999 : scratch_nxt;
  assign ovf    = ovf_q;
`else
  assign result = scratch_nxt;
  assign ovf    = 1'b0;
`endif

  // Datapath: capture, shift, and publish digits only when the conversion completes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      bin_sh  <= '0;
      scratch <= '0;
      done    <= 1'b0;
      bcd0    <= 4'd0;
      bcd1    <= 4'd0;
      bcd2    <= 4'd0;
      bcd3    <= 4'd0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        bin_sh  <= bin;
        scratch <= '0;
        cnt     <= CNT_W'(BIN_W);
      end else if (state == SHIFT) begin
        bin_sh  <= bin_nxt;
        scratch <= scratch_nxt;
        cnt     <= cnt - 1'b1;
      end
      if (last) begin
        done <= 1'b1;
        bcd0 <= result[3:0];
        bcd1 <= result[7:4];
        bcd2 <= result[11:8];
        bcd3 <= result[15:12];
      end
    end
  end

endmodule
